// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-requester RAM arbiter: requester indices,
// the round-robin priority pointer type and its reset value.
package ram_arbiter_pkg;

  localparam int REQ0 = 0;
  localparam int REQ1 = 1;

  // Which requester wins when both ask in the same cycle.
  typedef enum logic {
    PRIO_REQ0 = 1'b0,
    PRIO_REQ1 = 1'b1
  } prio_e;

  localparam prio_e PRIO_RESET = PRIO_REQ0;

  // After a grant, priority passes to the requester that was not served.
  function automatic prio_e prio_after(input logic granted_req1);
    return granted_req1 ? PRIO_REQ0 : PRIO_REQ1;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus between two requesters, the arbiter and one pseudo-dual-port RAM.
// Handshake: a requester raises *Request and holds it, with stable address/data,
// until the matching *Grant is high at a rising edge; that edge accepts the access.
interface ram_arbiter_if #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 8
) ();
  import ram_arbiter_pkg::*;

  logic                     ReadRequest0_i;
  logic [ADDRESS_WIDTH-1:0] ReadAddress0_i;
  logic                     ReadGrant0_o;
  logic                     ReadValid0_o;
  logic                     ReadRequest1_i;
  logic [ADDRESS_WIDTH-1:0] ReadAddress1_i;
  logic                     ReadGrant1_o;
  logic                     ReadValid1_o;
  logic [DATA_WIDTH-1:0]    ReadData_o;

  logic                     WriteRequest0_i;
  logic [ADDRESS_WIDTH-1:0] WriteAddress0_i;
  logic [DATA_WIDTH-1:0]    WriteData0_i;
  logic                     WriteGrant0_o;
  logic                     WriteRequest1_i;
  logic [ADDRESS_WIDTH-1:0] WriteAddress1_i;
  logic [DATA_WIDTH-1:0]    WriteData1_i;
  logic                     WriteGrant1_o;

  logic                     RamReadEnable_o;
  logic [ADDRESS_WIDTH-1:0] RamReadAddress_o;
  logic                     RamWriteEnable_o;
  logic [ADDRESS_WIDTH-1:0] RamWriteAddress_o;
  logic [DATA_WIDTH-1:0]    RamData_o;
  logic [DATA_WIDTH-1:0]    RamData_i;

  // Current priority pointers of the read and write arbiters.
  prio_e                    read_priority;
  prio_e                    write_priority;

  modport master (
    output ReadRequest0_i, ReadAddress0_i, ReadRequest1_i, ReadAddress1_i,
    output WriteRequest0_i, WriteAddress0_i, WriteData0_i,
    output WriteRequest1_i, WriteAddress1_i, WriteData1_i,
    output RamData_i,
    input  ReadGrant0_o, ReadValid0_o, ReadGrant1_o, ReadValid1_o, ReadData_o,
    input  WriteGrant0_o, WriteGrant1_o,
    input  RamReadEnable_o, RamReadAddress_o,
    input  RamWriteEnable_o, RamWriteAddress_o, RamData_o,
    input  read_priority, write_priority
  );

  modport slave (
    input  ReadRequest0_i, ReadAddress0_i, ReadRequest1_i, ReadAddress1_i,
    input  WriteRequest0_i, WriteAddress0_i, WriteData0_i,
    input  WriteRequest1_i, WriteAddress1_i, WriteData1_i,
    input  RamData_i,
    output ReadGrant0_o, ReadValid0_o, ReadGrant1_o, ReadValid1_o, ReadData_o,
    output WriteGrant0_o, WriteGrant1_o,
    output RamReadEnable_o, RamReadAddress_o,
    output RamWriteEnable_o, RamWriteAddress_o, RamData_o,
    output read_priority, write_priority
  );

endinterface

// File: rtl/ram_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter with a registered 1-bit priority pointer.
// Grants are combinational and suppressed while Reset is high.
module rr_arbiter2
  import ram_arbiter_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] request,
  output logic [1:0] grant,
  output prio_e      pointer
);

  prio_e pointer_next;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pointer <= PRIO_RESET;
    end else begin
      pointer <= pointer_next;
    end
  end

  always_comb begin
    grant        = 2'b00;
    pointer_next = pointer;
    if (!Reset) begin
      case (request)
        2'b01:   grant[REQ0] = 1'b1;
        2'b10:   grant[REQ1] = 1'b1;
        2'b11: begin
          if (pointer == PRIO_REQ0) grant[REQ0] = 1'b1;
          else                      grant[REQ1] = 1'b1;
        end
        default: grant = 2'b00;
      endcase
      // Pointer moves only when someone was served; idle cycles keep it.
      if (grant != 2'b00) pointer_next = prio_after(grant[REQ1]);
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two requesters onto one pseudo-dual-port RAM: independent read and
// write round-robin arbiters, 1-cycle read return with write-first bypass.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 8
) (
  input logic          Clock,
  input logic          Reset,
  ram_arbiter_if.slave bus
);

  logic [1:0]               read_grant;
  logic [1:0]               write_grant;
  prio_e                    read_pointer;
  prio_e                    write_pointer;

  logic                     ram_read_enable;
  logic [ADDRESS_WIDTH-1:0] ram_read_address;
  logic                     ram_write_enable;
  logic [ADDRESS_WIDTH-1:0] ram_write_address;
  logic [DATA_WIDTH-1:0]    ram_write_data;
  logic                     bypass_now;

  logic [1:0]               read_valid;
  logic                     bypass_hit;
  logic [DATA_WIDTH-1:0]    bypass_data;

  rr_arbiter2 u_read_arb (
    .Clock   (Clock),
    .Reset   (Reset),
    .request ({bus.ReadRequest1_i, bus.ReadRequest0_i}),
    .grant   (read_grant),
    .pointer (read_pointer)
  );

  rr_arbiter2 u_write_arb (
    .Clock   (Clock),
    .Reset   (Reset),
    .request ({bus.WriteRequest1_i, bus.WriteRequest0_i}),
    .grant   (write_grant),
    .pointer (write_pointer)
  );

  always_comb begin
    ram_read_enable   = |read_grant;
    ram_read_address  = '0;
    ram_write_enable  = |write_grant;
    ram_write_address = '0;
    ram_write_data    = '0;
    if (read_grant[REQ0])      ram_read_address = bus.ReadAddress0_i;
    else if (read_grant[REQ1]) ram_read_address = bus.ReadAddress1_i;
    if (write_grant[REQ0]) begin
      ram_write_address = bus.WriteAddress0_i;
      ram_write_data    = bus.WriteData0_i;
    end else if (write_grant[REQ1]) begin
      ram_write_address = bus.WriteAddress1_i;
      ram_write_data    = bus.WriteData1_i;
    end
  end

  // The RAM returns old data on a same-cycle read/write collision, so the
  // write data is captured here and substituted on the return path.
  assign bypass_now = ram_read_enable && ram_write_enable &&
                      (ram_read_address == ram_write_address);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      read_valid  <= 2'b00;
      bypass_hit  <= 1'b0;
      bypass_data <= '0;
    end else begin
      read_valid <= read_grant;
      bypass_hit <= bypass_now;
      if (bypass_now) bypass_data <= ram_write_data;
    end
  end

  assign bus.ReadGrant0_o      = read_grant[REQ0];
  assign bus.ReadGrant1_o      = read_grant[REQ1];
  assign bus.WriteGrant0_o     = write_grant[REQ0];
  assign bus.WriteGrant1_o     = write_grant[REQ1];

  // Reset drops an in-flight read immediately, not one cycle later.
  assign bus.ReadValid0_o      = read_valid[REQ0] & ~Reset;
  assign bus.ReadValid1_o      = read_valid[REQ1] & ~Reset;
  assign bus.ReadData_o        = (bypass_hit && !Reset) ? bypass_data : bus.RamData_i;

  assign bus.RamReadEnable_o   = ram_read_enable;
  assign bus.RamReadAddress_o  = ram_read_address;
  assign bus.RamWriteEnable_o  = ram_write_enable;
  assign bus.RamWriteAddress_o = ram_write_address;
  assign bus.RamData_o         = ram_write_data;

  assign bus.read_priority     = read_pointer;
  assign bus.write_priority    = write_pointer;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, per-cycle driver, and a reference model based
// on "last winner loses ties" plus a write-then-read memory image.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;

  logic Clock = 1'b0;
  logic Reset;

  ram_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Pseudo-dual-port RAM: registered read, read-before-write on collision.
  logic [DW-1:0] ram_mem [logic [AW-1:0]];
  always @(posedge Clock) begin : ram_model
    logic [DW-1:0] rd;
    rd = ram_mem.exists(bus.RamReadAddress_o) ? ram_mem[bus.RamReadAddress_o]
                                              : init_val(bus.RamReadAddress_o);
    if (bus.RamWriteEnable_o) ram_mem[bus.RamWriteAddress_o] = bus.RamData_o;
    if (bus.RamReadEnable_o) bus.RamData_i <= rd;
  end

  // Reference model state
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW:0]   exp_q [$];
  logic          last_rd, last_wr;

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) return last ? 2'b01 : 2'b10;
    return req;
  endfunction

  // Stimulus for the next cycle
  logic          s_rst;
  logic [1:0]    s_rr, s_wr;
  logic [AW-1:0] s_ra [2];
  logic [AW-1:0] s_wa [2];
  logic [DW-1:0] s_wd [2];

  // Observed and expected per cycle
  logic [1:0]    obs_rg, obs_wg, obs_valid;
  logic [DW-1:0] obs_rdata, obs_wd;
  logic          obs_re, obs_we;
  logic [AW-1:0] obs_ra, obs_wa;
  logic [1:0]    exp_rg, exp_wg, exp_valid;
  logic [DW-1:0] exp_rdata, exp_wd;
  logic [AW-1:0] exp_ra, exp_wa;

  task automatic tick();
    logic [DW:0] e;
    @(negedge Clock);
    Reset               = s_rst;
    bus.ReadRequest0_i  = s_rr[0];
    bus.ReadRequest1_i  = s_rr[1];
    bus.ReadAddress0_i  = s_ra[0];
    bus.ReadAddress1_i  = s_ra[1];
    bus.WriteRequest0_i = s_wr[0];
    bus.WriteRequest1_i = s_wr[1];
    bus.WriteAddress0_i = s_wa[0];
    bus.WriteAddress1_i = s_wa[1];
    bus.WriteData0_i    = s_wd[0];
    bus.WriteData1_i    = s_wd[1];
    #1;
    obs_rg    = {bus.ReadGrant1_o, bus.ReadGrant0_o};
    obs_wg    = {bus.WriteGrant1_o, bus.WriteGrant0_o};
    obs_valid = {bus.ReadValid1_o, bus.ReadValid0_o};
    obs_rdata = bus.ReadData_o;
    obs_re    = bus.RamReadEnable_o;
    obs_ra    = bus.RamReadAddress_o;
    obs_we    = bus.RamWriteEnable_o;
    obs_wa    = bus.RamWriteAddress_o;
    obs_wd    = bus.RamData_o;
    // Return of whatever was granted at the previous edge
    exp_valid = 2'b00;
    exp_rdata = '0;
    if (s_rst) begin
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      e         = exp_q.pop_front();
      exp_valid = e[DW] ? 2'b10 : 2'b01;
      exp_rdata = e[DW-1:0];
    end
    // Arbitration at the coming edge
    exp_rg = s_rst ? 2'b00 : rr_pick(s_rr, last_rd);
    exp_wg = s_rst ? 2'b00 : rr_pick(s_wr, last_wr);
    exp_ra = exp_rg[1] ? s_ra[1] : (exp_rg[0] ? s_ra[0] : '0);
    exp_wa = exp_wg[1] ? s_wa[1] : (exp_wg[0] ? s_wa[0] : '0);
    exp_wd = exp_wg[1] ? s_wd[1] : (exp_wg[0] ? s_wd[0] : '0);
    if (s_rst) begin
      last_rd = 1'b1;
      last_wr = 1'b1;
    end else begin
      if (exp_wg != 2'b00) begin
        ref_mem[exp_wa] = exp_wd;
        last_wr = exp_wg[1];
      end
      if (exp_rg != 2'b00) begin
        exp_q.push_back({exp_rg[1], ref_read(exp_ra)});
        last_rd = exp_rg[1];
      end
    end
  endtask

  task automatic idle_stim();
    s_rr = 2'b00;
    s_wr = 2'b00;
  endtask

  task automatic test_reset();
    s_rst = 1'b1; s_rr = 2'b11; s_wr = 2'b11;
    s_ra[0] = 16'h0005; s_ra[1] = 16'h0006;
    s_wa[0] = 16'h0007; s_wa[1] = 16'h0008;
    s_wd[0] = 8'h01;    s_wd[1] = 8'h02;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({obs_rg, obs_wg} !== 4'b0000) begin
        errors++; $display("FAIL reset_grants: got r=%b w=%b want 00/00", obs_rg, obs_wg);
      end
      checks++;
      if ({obs_valid, obs_re, obs_we} !== 4'b0000) begin
        errors++; $display("FAIL reset_valid_en: got v=%b re=%b we=%b want 0", obs_valid, obs_re, obs_we);
      end
    end
    checks++;
    if (bus.read_priority !== PRIO_REQ0 || bus.write_priority !== PRIO_REQ0) begin
      errors++; $display("FAIL reset_pointer: got r=%b w=%b want 0/0", bus.read_priority, bus.write_priority);
    end
    s_rst = 1'b0;
    tick();
    checks++;
    if (obs_rg !== 2'b01 || obs_wg !== 2'b01) begin
      errors++; $display("FAIL reset_first_grant: got r=%b w=%b want 01/01", obs_rg, obs_wg);
    end
  endtask

  task automatic test_read_contention();
    logic [1:0] prev;
    s_rr = 2'b11; s_wr = 2'b00;
    s_ra[0] = 16'h0010; s_ra[1] = 16'h0020;
    prev = 2'b00;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) idle_stim();
      tick();
      checks++;
      if (obs_rg !== exp_rg) begin
        errors++; $display("FAIL rd_cont_grant[%0d]: got %b want %b", i, obs_rg, exp_rg);
      end
      if (i > 0 && i < 6) begin
        checks++;
        if (obs_rg !== {prev[0], prev[1]}) begin
          errors++; $display("FAIL rd_cont_alternate[%0d]: got %b want %b", i, obs_rg, {prev[0], prev[1]});
        end
      end
      prev = obs_rg;
      checks++;
      if (obs_valid !== exp_valid) begin
        errors++; $display("FAIL rd_cont_valid[%0d]: got %b want %b", i, obs_valid, exp_valid);
      end
      if (exp_valid != 2'b00) begin
        checks++;
        if (obs_rdata !== exp_rdata) begin
          errors++; $display("FAIL rd_cont_data[%0d]: got %h want %h", i, obs_rdata, exp_rdata);
        end
      end
    end
  endtask

  task automatic test_single_requester();
    s_rr = 2'b10; s_wr = 2'b00;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) idle_stim();
      else s_ra[1] = AW'(i);
      tick();
      if (i < 5) begin
        checks++;
        if (obs_rg !== 2'b10) begin
          errors++; $display("FAIL single_grant[%0d]: got %b want 10", i, obs_rg);
        end
      end
      checks++;
      if (obs_valid !== exp_valid) begin
        errors++; $display("FAIL single_valid[%0d]: got %b want %b", i, obs_valid, exp_valid);
      end
      if (exp_valid != 2'b00) begin
        checks++;
        if (obs_rdata !== exp_rdata) begin
          errors++; $display("FAIL single_data[%0d]: got %h want %h", i, obs_rdata, exp_rdata);
        end
      end
    end
  endtask

  task automatic test_bypass();
    s_wr = 2'b01; s_wa[0] = 16'h0100; s_wd[0] = 8'hA5;
    s_rr = 2'b10; s_ra[1] = 16'h0100;
    tick();
    checks++;
    if (obs_rg !== 2'b10 || obs_wg !== 2'b01) begin
      errors++; $display("FAIL bypass_grant: got r=%b w=%b want 10/01", obs_rg, obs_wg);
    end
    s_wr = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) idle_stim();
      tick();
      checks++;
      if (obs_valid !== 2'b10 || obs_rdata !== 8'hA5) begin
        errors++; $display("FAIL bypass_data[%0d]: got v=%b d=%h want 10/a5", i, obs_valid, obs_rdata);
      end
      checks++;
      if (obs_rdata !== exp_rdata) begin
        errors++; $display("FAIL bypass_model[%0d]: got %h want %h", i, obs_rdata, exp_rdata);
      end
    end
  endtask

  task automatic test_write_contention();
    // A lone write by requester 1 hands write priority to requester 0.
    s_wr = 2'b10; s_wa[1] = 16'h0300; s_wd[1] = 8'h33; s_rr = 2'b00;
    tick();
    s_wr = 2'b11;
    s_wa[0] = 16'h0200; s_wd[0] = 8'h11;
    s_wa[1] = 16'h0200; s_wd[1] = 8'h22;
    tick();
    checks++;
    if (obs_wg !== 2'b01) begin
      errors++; $display("FAIL wr_cont_first: got %b want 01", obs_wg);
    end
    s_wr = 2'b10;
    tick();
    checks++;
    if (obs_wg !== 2'b10 || obs_wa !== 16'h0200 || obs_wd !== 8'h22) begin
      errors++; $display("FAIL wr_cont_second: got g=%b a=%h d=%h want 10/0200/22", obs_wg, obs_wa, obs_wd);
    end
    s_wr = 2'b00; s_rr = 2'b01; s_ra[0] = 16'h0200;
    tick();
    idle_stim();
    tick();
    checks++;
    if (obs_valid !== 2'b01 || obs_rdata !== 8'h22) begin
      errors++; $display("FAIL wr_cont_readback: got v=%b d=%h want 01/22", obs_valid, obs_rdata);
    end
  endtask

  task automatic test_reset_mid_read();
    s_rr = 2'b01; s_ra[0] = 16'h0030; s_wr = 2'b00;
    tick();
    checks++;
    if (obs_rg !== 2'b01) begin
      errors++; $display("FAIL midrst_grant: got %b want 01", obs_rg);
    end
    idle_stim(); s_rst = 1'b1;
    tick();
    checks++;
    if (obs_valid !== 2'b00) begin
      errors++; $display("FAIL midrst_dropped: got %b want 00", obs_valid);
    end
    s_rst = 1'b0;
    tick();
    checks++;
    if (bus.read_priority !== PRIO_REQ0 || obs_valid !== 2'b00) begin
      errors++; $display("FAIL midrst_after: got p=%b v=%b want 0/00", bus.read_priority, obs_valid);
    end
    s_rr = 2'b11; s_ra[1] = 16'h0031;
    tick();
    checks++;
    if (obs_rg !== 2'b01) begin
      errors++; $display("FAIL midrst_reissue: got %b want 01", obs_rg);
    end
    s_rr = 2'b00;
    tick();
    checks++;
    if (obs_valid !== 2'b01 || obs_rdata !== exp_rdata) begin
      errors++; $display("FAIL midrst_complete: got v=%b d=%h want 01/%h", obs_valid, obs_rdata, exp_rdata);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      s_rst   = (i < 398) && ($urandom_range(0, 49) == 0);
      s_rr    = (i < 398) ? 2'($urandom_range(0, 3)) : 2'b00;
      s_wr    = (i < 398) ? 2'($urandom_range(0, 3)) : 2'b00;
      for (int k = 0; k < 2; k++) begin
        s_ra[k] = 16'h0400 + AW'($urandom_range(0, 7));
        s_wa[k] = 16'h0400 + AW'($urandom_range(0, 7));
        s_wd[k] = DW'($urandom_range(0, 255));
      end
      tick();
      checks++;
      if (obs_rg !== exp_rg || obs_wg !== exp_wg) begin
        errors++; $display("FAIL rand_grant[%0d]: got r=%b w=%b want %b/%b", i, obs_rg, obs_wg, exp_rg, exp_wg);
      end
      checks++;
      if (obs_re !== (exp_rg != 2'b00) || obs_ra !== exp_ra) begin
        errors++; $display("FAIL rand_ram_rd[%0d]: got e=%b a=%h want a=%h", i, obs_re, obs_ra, exp_ra);
      end
      checks++;
      if (obs_we !== (exp_wg != 2'b00) || obs_wa !== exp_wa || obs_wd !== exp_wd) begin
        errors++; $display("FAIL rand_ram_wr[%0d]: got e=%b a=%h d=%h want a=%h d=%h", i, obs_we, obs_wa, obs_wd, exp_wa, exp_wd);
      end
      checks++;
      if (obs_valid !== exp_valid) begin
        errors++; $display("FAIL rand_valid[%0d]: got %b want %b", i, obs_valid, exp_valid);
      end
      if (exp_valid != 2'b00) begin
        checks++;
        if (obs_rdata !== exp_rdata) begin
          errors++; $display("FAIL rand_data[%0d]: got %h want %h", i, obs_rdata, exp_rdata);
        end
      end
    end
  endtask

  initial begin
    Reset   = 1'b1;
    s_rst   = 1'b1;
    s_rr    = 2'b00;
    s_wr    = 2'b00;
    s_ra[0] = '0; s_ra[1] = '0;
    s_wa[0] = '0; s_wa[1] = '0;
    s_wd[0] = '0; s_wd[1] = '0;
    last_rd = 1'b1;
    last_wr = 1'b1;
    test_reset();
    test_read_contention();
    test_single_requester();
    test_bypass();
    test_write_contention();
    test_reset_mid_read();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
